// File: rtl/ssp_pkg.sv
// Shared types and width helpers for the second-generation synchronous serial port.
package ssp_pkg;

    typedef enum logic [1:0] {
        TX_IDLE  = 2'd0,
        TX_SYNC  = 2'd1,
        TX_SHIFT = 2'd2
    } tx_state_e;

    // Occupancy counters need one extra bit so that "full" is distinct from "empty".
    function automatic int cnt_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

    function automatic int ptr_width(input int depth);
        return $clog2(depth);
    endfunction

endpackage

// File: rtl/ssp_fifo.sv
// Synchronous FIFO with occupancy count; push is ignored when full, pop is ignored when empty.
module ssp_fifo
    import ssp_pkg::*;
#(
    parameter  int WIDTH = 8,
    parameter  int DEPTH = 4,
    localparam int CW    = cnt_width(DEPTH),
    localparam int PW    = ptr_width(DEPTH)
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_rdata,
    output logic             o_empty,
    output logic [CW-1:0]    o_count
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_wptr;
    logic [PW-1:0]    r_rptr;
    logic [CW-1:0]    r_count;
    logic             w_full;
    logic             w_push;
    logic             w_pop;

    assign w_full  = (r_count == CW'(DEPTH));
    assign o_empty = (r_count == '0);
    assign w_push  = i_push && !w_full;
    assign w_pop   = i_pop && !o_empty;
    assign o_rdata = r_mem[r_rptr];
    assign o_count = r_count;

    // NOTE: the storage array has no reset; r_count alone says which entries are valid.
    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= i_wdata;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop sees pre-edge values.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + PW'(1);
            if (w_pop)  r_rptr <= r_rptr + PW'(1);
            unique case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/ssp_gen2.sv
// Second-generation SSP: CPU-side TX/RX FIFOs, master serial transmitter with
// back-to-back framing, slave receiver with synchronised inputs and overrun flag.
module ssp_gen2
    import ssp_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int CLK_DIV    = 4,
    parameter int TX_WMARK   = 1,
    parameter int RX_WMARK   = 1
) (
    input  logic                  PCLK,
    input  logic                  CLEAR_B,
    input  logic                  PSEL,
    input  logic                  PWRITE,
    input  logic [DATA_WIDTH-1:0] PWDATA,
    output logic [DATA_WIDTH-1:0] PRDATA,
    input  logic                  SSPCLKIN,
    input  logic                  SSPFSSIN,
    input  logic                  SSPRXD,
    output logic                  SSPCLKOUT,
    output logic                  SSPFSSOUT,
    output logic                  SSPTXD,
    output logic                  SSPOE_B,
    output logic                  SSPTXINTR,
    output logic                  SSPRXINTR,
    output logic                  SSPRORINTR
);

    localparam int CW   = cnt_width(FIFO_DEPTH);
    localparam int DIVW = $clog2(CLK_DIV);
    localparam int BCW  = $clog2(DATA_WIDTH) + 1;
    localparam logic [DIVW-1:0] DIV_LAST  = DIVW'(CLK_DIV - 1);
    localparam logic [DIVW-1:0] DIV_HALF  = DIVW'(CLK_DIV / 2 - 1);
    localparam logic [BCW-1:0]  BITS_LAST = BCW'(DATA_WIDTH - 1);
    localparam logic [BCW-1:0]  BITS_ALL  = BCW'(DATA_WIDTH);

    logic                  w_cpu_wr;
    logic                  w_cpu_rd;
    logic                  w_srise;
    logic                  w_tx_pop;
    logic [DATA_WIDTH-1:0] w_tx_rdata;
    logic                  w_tx_empty;
    logic [CW-1:0]         w_tx_count;
    logic                  w_rx_push;
    logic                  w_rx_last;
    logic                  w_rx_full;
    logic                  w_rx_fall;
    logic [DATA_WIDTH-1:0] w_rx_word;
    logic [DATA_WIDTH-1:0] w_rx_rdata;
    logic                  w_rx_empty;
    logic [CW-1:0]         w_rx_count;

    logic [DIVW-1:0]       r_div;
    logic                  r_clkout;
    tx_state_e             r_state;
    logic [DATA_WIDTH-1:0] r_tx_sh;
    logic [DATA_WIDTH-1:0] r_hold;
    logic                  r_held;
    logic [BCW-1:0]        r_tx_bits;
    logic                  r_fss;
    logic                  r_txd;
    logic                  r_oe_b;
    logic [2:0]            r_clkin_sync;
    logic [1:0]            r_fssin_sync;
    logic [1:0]            r_rxd_sync;
    logic                  r_armed;
    logic [BCW-1:0]        r_rx_bits;
    logic [DATA_WIDTH-1:0] r_rx_sh;
    logic [DATA_WIDTH-1:0] r_prdata;
    logic                  r_txintr;
    logic                  r_rxintr;
    logic                  r_ror;

    assign w_cpu_wr  = PSEL && PWRITE;
    assign w_cpu_rd  = PSEL && !PWRITE;
    assign w_srise   = (r_div == DIV_LAST);
    // The TX FIFO is popped when a frame starts from idle, or into the holding register while the LSB goes out.
    assign w_tx_pop  = w_srise && !w_tx_empty &&
                       ((r_state == TX_IDLE) || (r_state == TX_SHIFT && r_tx_bits == BCW'(1)));
    assign w_rx_fall = r_clkin_sync[2] && !r_clkin_sync[1];
    assign w_rx_word = {r_rx_sh[DATA_WIDTH-2:0], r_rxd_sync[1]};
    assign w_rx_last = w_rx_fall && r_armed && (r_rx_bits == BCW'(1));
    assign w_rx_full = (w_rx_count == CW'(FIFO_DEPTH));
    assign w_rx_push = w_rx_last && !w_rx_full;

    ssp_fifo #(.WIDTH(DATA_WIDTH), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .i_clk   (PCLK),
        .i_rst_n (CLEAR_B),
        .i_push  (w_cpu_wr),
        .i_wdata (PWDATA),
        .i_pop   (w_tx_pop),
        .o_rdata (w_tx_rdata),
        .o_empty (w_tx_empty),
        .o_count (w_tx_count)
    );

    ssp_fifo #(.WIDTH(DATA_WIDTH), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .i_clk   (PCLK),
        .i_rst_n (CLEAR_B),
        .i_push  (w_rx_push),
        .i_wdata (w_rx_word),
        .i_pop   (w_cpu_rd),
        .o_rdata (w_rx_rdata),
        .o_empty (w_rx_empty),
        .o_count (w_rx_count)
    );

    always_ff @(posedge PCLK or negedge CLEAR_B) begin
        if (!CLEAR_B) begin
            r_div    <= '0;
            r_clkout <= 1'b0;
        end else if (w_srise) begin
            r_div    <= '0;
            r_clkout <= 1'b1;
        end else begin
            r_div <= r_div + DIVW'(1);
            if (r_div == DIV_HALF) r_clkout <= 1'b0;
        end
    end

    always_ff @(posedge PCLK or negedge CLEAR_B) begin
        if (!CLEAR_B) begin
            r_state   <= TX_IDLE;
            r_tx_sh   <= '0;
            r_hold    <= '0;
            r_held    <= 1'b0;
            r_tx_bits <= '0;
            r_fss     <= 1'b0;
            r_txd     <= 1'b0;
            r_oe_b    <= 1'b1;
        end else if (w_srise) begin
            unique case (r_state)
                TX_IDLE: begin
                    if (!w_tx_empty) begin
                        r_tx_sh <= w_tx_rdata;
                        r_fss   <= 1'b1;
                        r_state <= TX_SYNC;
                    end
                end
                TX_SYNC: begin
                    r_fss     <= 1'b0;
                    r_txd     <= r_tx_sh[DATA_WIDTH-1];
                    r_tx_sh   <= r_tx_sh << 1;
                    r_oe_b    <= 1'b0;
                    r_tx_bits <= BITS_LAST;
                    r_state   <= TX_SHIFT;
                end
                TX_SHIFT: begin
                    if (r_tx_bits != '0) begin
                        r_txd     <= r_tx_sh[DATA_WIDTH-1];
                        r_tx_sh   <= r_tx_sh << 1;
                        r_tx_bits <= r_tx_bits - BCW'(1);
                        if (r_tx_bits == BCW'(1) && !w_tx_empty) begin
                            r_hold <= w_tx_rdata;
                            r_held <= 1'b1;
                            r_fss  <= 1'b1;
                        end
                    end else if (r_held) begin
                        r_fss     <= 1'b0;
                        r_held    <= 1'b0;
                        r_txd     <= r_hold[DATA_WIDTH-1];
                        r_tx_sh   <= r_hold << 1;
                        r_tx_bits <= BITS_LAST;
                    end else begin
                        r_txd   <= 1'b0;
                        r_oe_b  <= 1'b1;
                        r_state <= TX_IDLE;
                    end
                end
                default: r_state <= TX_IDLE;
            endcase
        end
    end

    // All three serial inputs see the same synchroniser delay, so data and frame sync stay aligned to the clock edge.
    always_ff @(posedge PCLK or negedge CLEAR_B) begin
        if (!CLEAR_B) begin
            r_clkin_sync <= '0;
            r_fssin_sync <= '0;
            r_rxd_sync   <= '0;
            r_armed      <= 1'b0;
            r_rx_bits    <= '0;
            r_rx_sh      <= '0;
        end else begin
            r_clkin_sync <= {r_clkin_sync[1:0], SSPCLKIN};
            r_fssin_sync <= {r_fssin_sync[0], SSPFSSIN};
            r_rxd_sync   <= {r_rxd_sync[0], SSPRXD};
            if (w_rx_fall) begin
                if (!r_armed) begin
                    if (r_fssin_sync[1]) begin
                        r_armed   <= 1'b1;
                        r_rx_bits <= BITS_ALL;
                    end
                end else begin
                    r_rx_sh <= w_rx_word;
                    if (r_rx_bits == BCW'(1)) begin
                        r_armed   <= r_fssin_sync[1];
                        r_rx_bits <= BITS_ALL;
                    end else begin
                        r_rx_bits <= r_rx_bits - BCW'(1);
                    end
                end
            end
        end
    end

    always_ff @(posedge PCLK or negedge CLEAR_B) begin
        if (!CLEAR_B) begin
            r_prdata <= '0;
            r_txintr <= 1'b0;
            r_rxintr <= 1'b0;
            r_ror    <= 1'b0;
        end else begin
            if (w_cpu_rd && !w_rx_empty) r_prdata <= w_rx_rdata;
            r_txintr <= (int'(w_tx_count) <= TX_WMARK);
            r_rxintr <= (int'(w_rx_count) >= RX_WMARK);
            if (w_rx_last && w_rx_full) r_ror <= 1'b1;
            else if (w_cpu_rd)          r_ror <= 1'b0;
        end
    end

    assign PRDATA     = r_prdata;
    assign SSPCLKOUT  = r_clkout;
    assign SSPFSSOUT  = r_fss;
    assign SSPTXD     = r_txd;
    assign SSPOE_B    = r_oe_b;
    assign SSPTXINTR  = r_txintr;
    assign SSPRXINTR  = r_rxintr;
    assign SSPRORINTR = r_ror;

endmodule

// File: tb/tb_ssp_gen2.sv
// Scoreboard bench for ssp_gen2: a serial-line decoder and CPU-read monitor check against queued expectations.
module tb_ssp_gen2;

    localparam int DW    = 8;
    localparam int DEPTH = 4;
    localparam int CDIV  = 4;
    localparam int RXW   = 1;
    localparam int DW2    = 12;
    localparam int DEPTH2 = 8;
    localparam int CDIV2  = 6;

    logic PCLK = 1'b0;
    logic CLEAR_B = 1'b0;

    logic          psel = 1'b0, pwrite = 1'b0;
    logic [DW-1:0] pwdata = '0;
    logic [DW-1:0] prdata;
    logic lb = 1'b0, tb_clk = 1'b0, tb_fss = 1'b0, tb_rxd = 1'b0;
    logic clkin, fssin, rxd;
    logic clkout, fssout, txd, oe_b, txintr, rxintr, rorintr;

    logic           psel2 = 1'b0, pwrite2 = 1'b0;
    logic [DW2-1:0] pwdata2 = '0;
    logic [DW2-1:0] prdata2;
    logic clkout2, fss2, txd2, oe2_b, txi2, rxi2, ror2;

    assign clkin = lb ? clkout : tb_clk;
    assign fssin = lb ? fssout : tb_fss;
    assign rxd   = lb ? txd    : tb_rxd;

    ssp_gen2 #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH), .CLK_DIV(CDIV), .TX_WMARK(1), .RX_WMARK(RXW)) u_dut (
        .PCLK(PCLK), .CLEAR_B(CLEAR_B), .PSEL(psel), .PWRITE(pwrite), .PWDATA(pwdata), .PRDATA(prdata),
        .SSPCLKIN(clkin), .SSPFSSIN(fssin), .SSPRXD(rxd),
        .SSPCLKOUT(clkout), .SSPFSSOUT(fssout), .SSPTXD(txd), .SSPOE_B(oe_b),
        .SSPTXINTR(txintr), .SSPRXINTR(rxintr), .SSPRORINTR(rorintr)
    );

    ssp_gen2 #(.DATA_WIDTH(DW2), .FIFO_DEPTH(DEPTH2), .CLK_DIV(CDIV2), .TX_WMARK(1), .RX_WMARK(1)) u_dut12 (
        .PCLK(PCLK), .CLEAR_B(CLEAR_B), .PSEL(psel2), .PWRITE(pwrite2), .PWDATA(pwdata2), .PRDATA(prdata2),
        .SSPCLKIN(clkout2), .SSPFSSIN(fss2), .SSPRXD(txd2),
        .SSPCLKOUT(clkout2), .SSPFSSOUT(fss2), .SSPTXD(txd2), .SSPOE_B(oe2_b),
        .SSPTXINTR(txi2), .SSPRXINTR(rxi2), .SSPRORINTR(ror2)
    );

    always #5 PCLK = ~PCLK;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: words in flight on the serial line, words held by the RX FIFO, sticky overrun, last read value.
    logic [DW-1:0] tx_exp[$];
    logic [DW-1:0] rx_exp[$];
    logic          exp_ror = 1'b0;
    logic [DW-1:0] last_prd = '0;

    logic          mon_prev_clk = 1'b0;
    logic          mon_armed = 1'b0;
    int            mon_cnt = 0;
    logic [DW-1:0] mon_sh = '0;
    int            sent = 0;
    int            fss_run = 0, fss_len = 0, oe_run = 0, oe_len = 0;
    logic          fss_in_data = 1'b0;

    always @(posedge PCLK) begin
        logic rd;
        logic [DW-1:0] w;
        rd = CLEAR_B && psel && !pwrite;
        #1;
        if (!CLEAR_B) begin
            tx_exp.delete();
            rx_exp.delete();
            exp_ror = 1'b0;
            last_prd = '0;
            mon_armed = 1'b0;
            mon_prev_clk = 1'b0;
            fss_run = 0;
            oe_run = 0;
        end else begin
            if (rd) begin
                if (rx_exp.size() > 0) last_prd = rx_exp.pop_front();
                exp_ror = 1'b0;
                check("prdata", prdata, last_prd);
            end
            if (fssout) fss_run++;
            else begin
                if (fss_run > 0) fss_len = fss_run;
                fss_run = 0;
            end
            if (!oe_b) oe_run++;
            else begin
                if (oe_run > 0) oe_len = oe_run;
                oe_run = 0;
            end
            if (fssout && !oe_b) fss_in_data = 1'b1;
            // Frame decoder on the transmit line, sampling at SSPCLKOUT falling edges.
            if (mon_prev_clk && !clkout) begin
                if (!mon_armed) begin
                    if (fssout) begin
                        mon_armed = 1'b1;
                        mon_cnt = DW;
                    end
                end else begin
                    mon_sh = {mon_sh[DW-2:0], txd};
                    check("oe_b_during_bit", oe_b, 1'b0);
                    mon_cnt--;
                    if (mon_cnt == 0) begin
                        mon_armed = fssout;
                        mon_cnt = DW;
                        sent++;
                        check("tx_word_expected", tx_exp.size() > 0, 1'b1);
                        if (tx_exp.size() > 0) begin
                            w = tx_exp.pop_front();
                            check("txd_word", mon_sh, w);
                            if (lb) begin
                                if (rx_exp.size() < DEPTH) rx_exp.push_back(w);
                                else exp_ror = 1'b1;
                            end
                        end
                    end
                end
            end
            mon_prev_clk = clkout;
        end
    end

    // All CPU tasks are entered at a PCLK falling edge and return at one.
    task automatic cpu_write(input logic [DW-1:0] w);
        psel = 1'b1;
        pwrite = 1'b1;
        pwdata = w;
        tx_exp.push_back(w);
        @(negedge PCLK);
        psel = 1'b0;
        pwrite = 1'b0;
    endtask

    task automatic cpu_read();
        psel = 1'b1;
        pwrite = 1'b0;
        @(negedge PCLK);
        psel = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge PCLK);
    endtask

    task automatic wait_quiet();
        int t = 0;
        while ((tx_exp.size() != 0 || !oe_b) && t < 3000) begin
            @(negedge PCLK);
            t++;
        end
        check("quiet_timeout", t < 3000, 1'b1);
        idle(4 * CDIV + 8);
    endtask

    task automatic clear_meas();
        fss_len = 0;
        oe_len = 0;
        fss_in_data = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    initial begin
        int n;
        int t;
        int t0;
        logic seen_low;
        logic [DW-1:0] ov_words [6];
        ov_words[0] = 8'h94; ov_words[1] = 8'h0F; ov_words[2] = 8'h51;
        ov_words[3] = 8'h24; ov_words[4] = 8'h67; ov_words[5] = 8'hF3;

        // Reset held while every input is toggled.
        repeat (12) begin
            @(negedge PCLK);
            psel = 1'($urandom); pwrite = 1'($urandom); pwdata = DW'($urandom);
            tb_clk = 1'($urandom); tb_fss = 1'($urandom); tb_rxd = 1'($urandom);
            psel2 = 1'($urandom); pwrite2 = 1'($urandom); pwdata2 = DW2'($urandom);
        end
        @(negedge PCLK);
        psel = 0; pwrite = 0; tb_clk = 0; tb_fss = 0; tb_rxd = 0; psel2 = 0; pwrite2 = 0;
        check("rst_prdata", prdata, 0);
        check("rst_clkout", clkout, 0);
        check("rst_fssout", fssout, 0);
        check("rst_txd", txd, 0);
        check("rst_oe_b", oe_b, 1);
        check("rst_txintr", txintr, 0);
        check("rst_rxintr", rxintr, 0);
        check("rst_ror", rorintr, 0);
        check("rst_prdata12", prdata2, 0);
        check("rst_oe_b12", oe2_b, 1);
        CLEAR_B = 1'b1;
        @(posedge PCLK);
        #1;
        check("txintr_after_release", txintr, 1);
        check("txintr12_after_release", txi2, 1);
        @(negedge PCLK);

        // TX overflow with the receive side idle.
        sent = 0;
        for (int i = 0; i < 6; i++) cpu_write(ov_words[i]);
        idle(400);
        check("ovf_sent_4_or_5", (sent == 4 || sent == 5), 1);
        check("ovf_txintr", txintr, 1);
        check("ovf_rxintr", rxintr, 0);
        tx_exp.delete();

        // Single-word loopback.
        lb = 1'b1;
        idle(8);
        clear_meas();
        cpu_write(8'h35);
        wait_quiet();
        check("lb_fss_len", fss_len, CDIV);
        check("lb_oe_len", oe_len, 8 * CDIV);
        check("lb_fss_in_data", fss_in_data, 0);
        check("lb_rxintr", rxintr, 1);
        cpu_read();
        idle(2);
        check("lb_rxintr_after_read", rxintr, 0);

        // Back-to-back framing.
        clear_meas();
        cpu_write(8'hAE);
        cpu_write(8'h26);
        wait_quiet();
        check("b2b_oe_len", oe_len, 16 * CDIV);
        check("b2b_fss_len", fss_len, CDIV);
        check("b2b_fss_in_data", fss_in_data, 1);
        check("b2b_rxintr", rxintr, 1);
        cpu_read();
        cpu_read();
        idle(2);
        check("b2b_rxintr_after_read", rxintr, 0);

        // Receive overrun: five words, no reads.
        for (int i = 0; i < 5; i++) begin
            cpu_write(DW'($urandom));
            idle(10);
        end
        wait_quiet();
        check("ovr_ror_model", exp_ror, 1);
        check("ovr_ror", rorintr, exp_ror);
        check("ovr_rxintr", rxintr, 1);
        cpu_read();
        check("ovr_ror_cleared", rorintr, exp_ror);
        for (int i = 0; i < DEPTH - 1; i++) cpu_read();
        idle(2);
        check("ovr_rxintr_drained", rxintr, 0);

        // Randomised rounds; the first is a burst of four writes to exercise the TX watermark.
        for (int r = 0; r < 5; r++) begin
            n = (r == 0) ? 4 : $urandom_range(1, 4);
            for (int i = 0; i < n; i++) begin
                cpu_write(DW'($urandom));
                if (r != 0) idle($urandom_range(0, 5));
            end
            if (r == 0) begin
                idle(1);
                check("txintr_busy", txintr, 0);
            end
            wait_quiet();
            check("rnd_txintr", txintr, 1);
            check("rnd_rxintr", rxintr, rx_exp.size() >= RXW);
            check("rnd_ror", rorintr, exp_ror);
            for (int i = 0; i <= n; i++) cpu_read();
            idle(2);
            check("rnd_rxintr_after", rxintr, rx_exp.size() >= RXW);
        end

        // Reset in the middle of a frame must not leave a partial word behind.
        cpu_write(8'h5A);
        t = 0;
        while (oe_b && t < 500) begin
            @(negedge PCLK);
            t++;
        end
        check("midrst_start_timeout", t < 500, 1);
        idle(3 * CDIV);
        CLEAR_B = 1'b0;
        #1;
        check("midrst_oe_b", oe_b, 1);
        check("midrst_fssout", fssout, 0);
        check("midrst_txd", txd, 0);
        idle(2);
        CLEAR_B = 1'b1;
        idle(20 * CDIV);
        check("midrst_rxintr", rxintr, 0);
        check("midrst_ror", rorintr, 0);
        cpu_read();
        idle(1);

        // Wide-word, deep-FIFO, slower-clock instance.
        psel2 = 1'b1; pwrite2 = 1'b1; pwdata2 = 12'hA5C;
        @(negedge PCLK);
        psel2 = 1'b0; pwrite2 = 1'b0;
        t = 0;
        while (!fss2 && t < 500) begin
            @(posedge PCLK);
            #1;
            t++;
        end
        check("w12_fss_timeout", t < 500, 1);
        t0 = t;
        seen_low = 1'b0;
        while (!(seen_low && oe2_b) && t < 1000) begin
            @(posedge PCLK);
            #1;
            t++;
            if (!oe2_b) seen_low = 1'b1;
        end
        check("w12_frame_len", t - t0, 13 * CDIV2);
        idle(40);
        check("w12_rxintr", rxi2, 1);
        psel2 = 1'b1; pwrite2 = 1'b0;
        @(posedge PCLK);
        #1;
        check("w12_prdata", prdata2, 12'hA5C);
        check("w12_ror", ror2, 0);
        @(negedge PCLK);
        psel2 = 1'b0;
        idle(4);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
